// File: rtl/sprite_ram_writer_if.sv
// Pixel-stream and sprite-RAM write bus for sprite_ram_writer.
// master: the block feeding pixels and consuming writes; slave: the writer.
interface sprite_ram_writer_if #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
);
  logic              start;
  logic [1:0]        bank;
  logic              abort;
  logic              in_valid;
  logic [IDX_W-1:0]  in_data;
  logic              in_ready;
  logic              wr_en;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, bank, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, bank, abort, in_valid, in_data,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/sprite_ram_writer.sv
// Streams palette indices of one sprite (raster order) into the selected
// sprite RAM bank; one registered write per accepted pixel.
module sprite_ram_writer #(
  parameter int NUM_PIXELS = 576,
  parameter int ADDR_W     = 10,
  parameter int IDX_W      = 4
) (
  input logic              Clk,
  input logic              Reset,
  sprite_ram_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        bank_q;
  logic              xfer;
  logic              start_ok;
  logic              start_bad;
  logic              in_ready_c;
  logic              busy_c;
  logic              done_c;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake and status decode
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        start_ok  = bus.start && (bus.bank != 2'd3);
        start_bad = bus.start && (bus.bank == 2'd3);
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        busy_c     = 1'b1;
        in_ready_c = !bus.abort;
        xfer       = bus.in_valid && !bus.abort;
        if (bus.abort)                      state_nxt = IDLE;
        else if (xfer && cnt == LAST_PIXEL) state_nxt = DONE;
      end
      DONE: begin
        // The final pixel's write lands in this same cycle.
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

  // Pixel counter and latched target bank
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      bank_q <= '0;
    end else if (start_ok) begin
      cnt    <= '0;
      bank_q <= bus.bank;
    end else if (xfer && cnt != LAST_PIXEL) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered write port and error pulse; write fields hold between strobes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_bank <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.error   <= 1'b0;
    end else begin
      bus.wr_en <= xfer;
      bus.error <= start_bad;
      if (xfer) begin
        bus.wr_bank <= bank_q;
        bus.wr_addr <= cnt;
        bus.wr_data <= bus.in_data;
      end
    end
  end

endmodule
